// File: rtl/seg_display_mux_if.sv
// seg_display_mux_if: user-side data/dp/brightness inputs and sel/seg/frame display outputs.
interface seg_display_mux_if #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned BRIGHT_W = 8
);
  logic [4*DIGITS-1:0] data;
  logic [DIGITS-1:0]   dp;
  logic [BRIGHT_W-1:0] brightness;
  logic                frame;
  logic [DIGITS-1:0]   sel;
  logic [7:0]          seg;

  // User logic drives the values, the display driver drives the pins
  modport master (output data, dp, brightness, input frame, sel, seg);
  modport slave  (input data, dp, brightness, output frame, sel, seg);
endinterface

// File: rtl/seg_display_mux.sv
// seg_display_mux: time-multiplexed common-anode 7-segment driver.
// Each digit slot starts with an anti-ghosting blank, then the digit is lit for
// brightness*STEP_TICKS ticks. Inputs are latched once per frame so digits never tear.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank digits above the most
// significant nonzero nibble (digit 0 always shown).
module seg_display_mux #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned BLANK_TICKS = 10,
  parameter int unsigned STEP_TICKS  = 1,
  parameter int unsigned BRIGHT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  seg_display_mux_if.slave bus
);

  localparam int unsigned SLOT   = BLANK_TICKS + ((32'd1 << BRIGHT_W) - 32'd1) * STEP_TICKS;
  localparam int unsigned CNT_W  = (SLOT > 1) ? $clog2(SLOT) : 1;
  localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned DATA_W = 4 * DIGITS;
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(SLOT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   data_sh_q, data_sh_d;
  logic [DIGITS-1:0]   dp_sh_q, dp_sh_d;
  logic [BRIGHT_W-1:0] bright_sh_q, bright_sh_d;
  logic                load_pend_q, load_pend_d;
  logic                frame_q, frame_d;
  logic [DIGITS-1:0]   sel_q, sel_d;
  logic [7:0]          seg_q, seg_d;

  logic                slot_end;
  logic                frame_wrap;
  logic                shadow_load;
  logic [3:0]          nib;
  logic                dp_bit;
  logic [31:0]         tick;
  logic [31:0]         on_end;
  logic [DIGITS-1:0]   digit_sel;
  logic                blank_lead;

  // Active-low segment pattern, bit6=G .. bit0=A
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'h0:    p = 7'b1000000;
      4'h1:    p = 7'b1111001;
      4'h2:    p = 7'b0100100;
      4'h3:    p = 7'b0110000;
      4'h4:    p = 7'b0011001;
      4'h5:    p = 7'b0010010;
      4'h6:    p = 7'b0000010;
      4'h7:    p = 7'b1111000;
      4'h8:    p = 7'b0000000;
      4'h9:    p = 7'b0010000;
      4'hA:    p = 7'b0001000;
      4'hB:    p = 7'b0000011;
      4'hC:    p = 7'b1000110;
      4'hD:    p = 7'b0100001;
      4'hE:    p = 7'b0000110;
      4'hF:    p = 7'b0001110;
      default: p = 7'b1111111;
    endcase
    return p;
  endfunction

  // Tick/digit counters, frame pulse and once-per-frame shadow capture
  always_comb begin
    slot_end    = (cnt_q == LAST_TICK);
    frame_wrap  = slot_end && (idx_q == LAST_IDX);
    shadow_load = frame_wrap || load_pend_q;
    cnt_d       = slot_end ? '0 : cnt_q + CNT_W'(1);
    idx_d       = idx_q;
    if (slot_end) begin
      idx_d = frame_wrap ? '0 : idx_q + IDX_W'(1);
    end
    frame_d     = frame_wrap;
    load_pend_d = 1'b0;
    data_sh_d   = shadow_load ? bus.data       : data_sh_q;
    dp_sh_d     = shadow_load ? bus.dp         : dp_sh_q;
    bright_sh_d = shadow_load ? bus.brightness : bright_sh_q;
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [IDX_W-1:0] msd;

  // Locate the most significant nonzero nibble; digits above it are blank
  always_comb begin
    msd = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (data_sh_q[4*k +: 4] != 4'h0) begin
        msd = IDX_W'(k);
      end
    end
    blank_lead = (idx_q > msd);
  end
`else
  assign blank_lead = 1'b0;
`endif

  // Next sel/seg for the current tick: blank lead-in, PWM on window, dark tail
  always_comb begin
    sel_d     = '1;
    seg_d     = 8'hFF;
    nib       = data_sh_q[{idx_q, 2'b00} +: 4];
    dp_bit    = dp_sh_q[idx_q];
    tick      = 32'(cnt_q);
    on_end    = 32'(BLANK_TICKS) + 32'(bright_sh_q) * 32'(STEP_TICKS);
    digit_sel = ~(DIGITS'(1) << idx_q);
    if ((tick >= 32'(BLANK_TICKS)) && (tick < on_end)) begin
      if (!blank_lead) begin
        sel_d = digit_sel;
        seg_d = {~dp_bit, hex_to_seg(nib)};
      end else if (dp_bit) begin
        sel_d = digit_sel;
        seg_d = 8'h7F;
      end
    end
  end

  // State and registered outputs; reset blanks the display without a clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      data_sh_q   <= '0;
      dp_sh_q     <= '0;
      bright_sh_q <= '0;
      load_pend_q <= 1'b1;
      frame_q     <= 1'b0;
      sel_q       <= '1;
      seg_q       <= 8'hFF;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      data_sh_q   <= data_sh_d;
      dp_sh_q     <= dp_sh_d;
      bright_sh_q <= bright_sh_d;
      load_pend_q <= load_pend_d;
      frame_q     <= frame_d;
      sel_q       <= sel_d;
      seg_q       <= seg_d;
    end
  end

  assign bus.frame = frame_q;
  assign bus.sel   = sel_q;
  assign bus.seg   = seg_q;

endmodule

// File: tb/tb_seg_display_mux.sv
// tb_seg_display_mux: cycle-accurate reference model derived from the edge count
// since reset, checked every cycle, plus literal per-frame expectations.
module tb_seg_display_mux;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned BLANK  = 10;
  localparam int unsigned STEP   = 1;
  localparam int unsigned BW     = 8;
  localparam int unsigned SLOT   = BLANK + 255 * STEP;
  localparam int unsigned FRAME  = DIGITS * SLOT;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  localparam logic [6:0] PAT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  seg_display_mux_if #(.DIGITS(DIGITS), .BRIGHT_W(BW)) bus ();

  seg_display_mux #(
    .DIGITS(DIGITS), .BLANK_TICKS(BLANK), .STEP_TICKS(STEP), .BRIGHT_W(BW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  initial forever #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: output after edge n+1 is fixed by tick n%SLOT of digit (n/SLOT)%DIGITS
  function automatic logic [11:0] model_out(input int unsigned n, input logic [15:0] dat,
                                            input logic [3:0] dpv, input logic [7:0] br);
    int unsigned t, d, msd;
    logic [3:0] nib, s;
    logic [7:0] g;
    t = n % SLOT;
    d = (n / SLOT) % DIGITS;
    s = 4'hF;
    g = 8'hFF;
    nib = 4'(dat >> (4 * d));
    msd = 0;
    for (int i = 0; i < int'(DIGITS); i++) if (4'(dat >> (4 * i)) != 4'h0) msd = i;
    if (t >= BLANK && t < BLANK + 32'(br) * STEP) begin
      if (LZB && d > msd) begin
        if (dpv[d]) begin
          s = ~(4'b1 << d);
          g = 8'h7F;
        end
      end else begin
        s = ~(4'b1 << d);
        g = {~dpv[d], PAT[nib]};
      end
    end
    return {s, g};
  endfunction

  int unsigned k_edge = 0;
  logic [15:0] m_data = '0;
  logic [3:0]  m_dp   = '0;
  logic [7:0]  m_br   = '0;
  logic [3:0]  exp_sel   = 4'hF;
  logic [7:0]  exp_seg   = 8'hFF;
  logic        exp_frame = 1'b0;

  // Model state: edge count since reset release and the inputs latched per frame
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_edge    <= 0;
      m_data    <= '0;
      m_dp      <= '0;
      m_br      <= '0;
      exp_sel   <= 4'hF;
      exp_seg   <= 8'hFF;
      exp_frame <= 1'b0;
    end else begin
      k_edge            <= k_edge + 1;
      {exp_sel, exp_seg} <= model_out(k_edge, m_data, m_dp, m_br);
      exp_frame         <= ((k_edge + 1) % FRAME) == 0;
      if (k_edge == 0 || ((k_edge + 1) % FRAME) == 0) begin
        m_data <= bus.data;
        m_dp   <= bus.dp;
        m_br   <= bus.brightness;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of the pins against the model
  task automatic monitor();
    forever begin
      @(negedge clk);
      n_tests++;
      if (bus.sel !== exp_sel || bus.seg !== exp_seg || bus.frame !== exp_frame) begin
        n_fail++;
        $display("FAIL cycle: sel=%h exp %h, seg=%h exp %h, frame=%b exp %b at %0t",
                 bus.sel, exp_sel, bus.seg, exp_seg, bus.frame, exp_frame, $time);
      end
    end
  endtask

  int          obs_cnt [4];
  logic [7:0]  obs_seg [4];
  int          obs_dp_low, obs_first_on, obs_first_dig, obs_frames;

  task automatic observe(input int unsigned ncyc);
    for (int i = 0; i < 4; i++) begin
      obs_cnt[i] = 0;
      obs_seg[i] = 8'hFF;
    end
    obs_dp_low = 0; obs_first_on = -1; obs_first_dig = -1; obs_frames = 0;
    for (int c = 0; c < int'(ncyc); c++) begin
      @(negedge clk);
      if (bus.frame) obs_frames++;
      if (!bus.seg[7]) obs_dp_low++;
      for (int i = 0; i < 4; i++) begin
        if (bus.sel == ~(4'b1 << i)) begin
          obs_cnt[i]++;
          obs_seg[i] = bus.seg;
          if (obs_first_on < 0) begin
            obs_first_on  = c;
            obs_first_dig = i;
          end
        end
      end
    end
  endtask

  task automatic wait_frame();
    int c = 0;
    bit seen = 1'b0;
    while (!seen && c < int'(FRAME) + 20) begin
      @(negedge clk);
      c++;
      if (bus.frame) seen = 1'b1;
    end
    check("frame_pulse_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    bus.data = '0; bus.dp = '0; bus.brightness = '0;
    #1 rst_n = 1'b0;
    #1;
    check("reset_sel_no_clk", 32'(bus.sel), 32'hF);
    check("reset_seg_no_clk", 32'(bus.seg), 32'hFF);
    check("reset_frame_no_clk", 32'(bus.frame), 32'd0);
    fork monitor(); join_none
    repeat (5) @(negedge clk);

    // First frame after reset shows live data at full brightness
    bus.data = 16'h0158; bus.dp = 4'h0; bus.brightness = 8'hFF;
    rst_n = 1'b1;
    observe(FRAME);
    check("t2_first_on_tick", 32'(obs_first_on), 32'd10);
    check("t2_first_digit", 32'(obs_first_dig), 32'd0);
    check("t2_on_d0", 32'(obs_cnt[0]), 32'd255);
    check("t2_on_d3", 32'(obs_cnt[3]), 32'd255);
    check("t2_seg_d0", 32'(obs_seg[0]), 32'h80);
    check("t2_seg_d1", 32'(obs_seg[1]), 32'h92);
    check("t2_seg_d2", 32'(obs_seg[2]), 32'hF9);
    check("t2_seg_d3", 32'(obs_seg[3]), 32'hC0);
    check("t2_frames", 32'(obs_frames), 32'd1);

    // PWM width
    bus.brightness = 8'd4;
    wait_frame();
    observe(FRAME);
    check("t3_b4_d0", 32'(obs_cnt[0]), 32'd4);
    check("t3_b4_d2", 32'(obs_cnt[2]), 32'd4);
    bus.brightness = 8'd0;
    wait_frame();
    observe(FRAME);
    check("t3_b0_total", 32'(obs_cnt[0] + obs_cnt[1] + obs_cnt[2] + obs_cnt[3]), 32'd0);

    // Mid-frame data change waits for the frame boundary
    bus.data = 16'h1234; bus.brightness = 8'hFF;
    wait_frame();
    repeat (500) @(negedge clk);
    bus.data = 16'hABCD;
    observe(FRAME - 500);
    check("t4_old_d2", 32'(obs_seg[2]), 32'hA4);
    check("t4_old_d3", 32'(obs_seg[3]), 32'hF9);
    observe(FRAME);
    check("t4_new_d0", 32'(obs_seg[0]), 32'hA1);
    check("t4_new_d1", 32'(obs_seg[1]), 32'hC6);
    check("t4_new_d2", 32'(obs_seg[2]), 32'h83);
    check("t4_new_d3", 32'(obs_seg[3]), 32'h88);

    // Decimal point follows its digit
    bus.data = 16'h0158; bus.dp = 4'b0100;
    wait_frame();
    observe(FRAME);
    check("t5_dp_low_cycles", 32'(obs_dp_low), 32'd255);
    check("t5_dp_d2", 32'(obs_seg[2]), 32'h79);
    check("t5_dp_d0", 32'(obs_seg[0]), 32'h80);

    // Leading-zero handling
    bus.data = 16'h0007; bus.dp = 4'h0;
    wait_frame();
    observe(FRAME);
    check("t6_d0_seg", 32'(obs_seg[0]), 32'hF8);
`ifdef LEADING_ZERO_BLANK_EN
    check("t6_lzb_d3_off", 32'(obs_cnt[3]), 32'd0);
    bus.data = 16'h0000;
    wait_frame();
    observe(FRAME);
    check("t6_lzb_zero_d0", 32'(obs_seg[0]), 32'hC0);
    check("t6_lzb_zero_d1_off", 32'(obs_cnt[1]), 32'd0);
    bus.dp = 4'b1000;
    wait_frame();
    observe(FRAME);
    check("t6_lzb_dp_d3", 32'(obs_seg[3]), 32'h7F);
`else
    check("t6_d3_on", 32'(obs_cnt[3]), 32'd255);
    check("t6_d3_zero", 32'(obs_seg[3]), 32'hC0);
`endif

    // Randomized traffic, inputs changing at arbitrary cycles
    for (int it = 0; it < 15; it++) begin
      int unsigned r;
      bus.data = 16'($urandom);
      bus.dp   = 4'($urandom);
      r = $urandom_range(0, 3);
      bus.brightness = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'($urandom);
      repeat ($urandom_range(1, 1500)) @(negedge clk);
    end

    // Asynchronous reset in the middle of a slot
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_sel", 32'(bus.sel), 32'hF);
    check("midreset_seg", 32'(bus.seg), 32'hFF);
    check("midreset_frame", 32'(bus.frame), 32'd0);
    repeat (3) @(negedge clk);
    bus.data = 16'($urandom); bus.dp = 4'($urandom); bus.brightness = 8'($urandom);
    rst_n = 1'b1;
    repeat (2 * FRAME + 50) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete, time=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
